// File: rtl/pa_riscv_pkg.sv
// Shared types and constants for the memory responder slice.
// Holds the responder FSM encoding and the word size in bytes.
package pa_riscv;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_RESPOND
    } memRspState_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/memory_responder_word_ram.sv
// DEPTH_WORDS x 32 array with one synchronous write port and one registered read port.
// Contents are never reset.
module word_ram #(
    parameter int    DEPTH_WORDS = 64,
    parameter string MEM_INIT    = "",
    localparam int   IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_waddr] <= i_wdata;
        rdata_q <= mem_q[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Single-outstanding memory responder: valid/ready request in, valid/ready response out.
// Response valid LATENCY+1 cycles after accept; held stable until i_rspReady, no new request meanwhile.
module memory_responder
    import pa_riscv::*;
#(
    parameter int    DEPTH_WORDS = 64,
    parameter int    LATENCY     = 2,
    parameter string MEM_INIT    = ""
) (
    input  logic        i_clk,
    input  logic        i_arst,
    input  logic        i_reqValid,
    output logic        o_reqReady,
    input  logic [31:0] i_reqAddress,
    input  logic        i_reqWriteEn,
    input  logic [31:0] i_reqWriteData,
    output logic        o_rspValid,
    input  logic        i_rspReady,
    output logic [31:0] o_rspReadData,
    output logic        o_rspError
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam int          OFS_W    = $clog2(WORD_BYTES);
    localparam logic [3:0]  LAT_INIT = 4'(LATENCY);
    localparam logic [29:0] DEPTH_30 = 30'(DEPTH_WORDS);

    memRspState_t state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic         we_q, we_d;
    logic         vld_q, vld_d;
    logic         err_q, err_d;
    logic [31:0]  rdata_q, rdata_d;

    logic             req_err;
    logic             ram_we;
    logic [IDX_W-1:0] ram_raddr;
    logic [31:0]      ram_rdata;

    assign req_err = (addr_q[OFS_W-1:0] != '0) || (addr_q[31:OFS_W] >= DEPTH_30);
    assign ram_we  = (state_q == MEM_RESPOND) && !vld_q && we_q && !req_err;

    // In IDLE the read port follows the incoming address so LATENCY=0 still has data one edge later.
    assign ram_raddr = (state_q == MEM_IDLE) ? i_reqAddress[IDX_W+OFS_W-1:OFS_W]
                                             : addr_q[IDX_W+OFS_W-1:OFS_W];

    word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .MEM_INIT    (MEM_INIT)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_waddr (addr_q[IDX_W+OFS_W-1:OFS_W]),
        .i_wdata (wdata_q),
        .i_raddr (ram_raddr),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        vld_d   = vld_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            MEM_IDLE: begin
                if (i_reqValid) begin
                    addr_d  = i_reqAddress;
                    we_d    = i_reqWriteEn;
                    wdata_d = i_reqWriteData;
                    cnt_d   = LAT_INIT;
                    state_d = (LAT_INIT != 4'd0) ? MEM_WAIT : MEM_RESPOND;
                end
            end
            MEM_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = MEM_RESPOND;
            end
            MEM_RESPOND: begin
                // First edge in RESPOND commits the access; later edges only wait for the handshake.
                if (!vld_q) begin
                    vld_d   = 1'b1;
                    err_d   = req_err;
                    rdata_d = (req_err || we_q) ? 32'd0 : ram_rdata;
                end else if (i_rspReady) begin
                    vld_d   = 1'b0;
                    err_d   = 1'b0;
                    rdata_d = 32'd0;
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_reqReady    = (state_q == MEM_IDLE);
    assign o_rspValid    = vld_q;
    assign o_rspReadData = rdata_q;
    assign o_rspError    = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (LATENCY 2, 0, 4) driven by directed steps then random requests.
// Expected responses come from a word-array model with per-word "written" flags.
module tb_memory_responder;

    localparam int DEPTH = 64;

    logic        clk;
    logic        arst;
    logic        req_vld  [3];
    logic        req_rdy  [3];
    logic [31:0] req_adr  [3];
    logic        req_we   [3];
    logic [31:0] req_wd   [3];
    logic        rsp_vld  [3];
    logic        rsp_rdy  [3];
    logic [31:0] rsp_dat  [3];
    logic        rsp_err  [3];

    int vectors;
    int miscompares;

    logic [31:0] ref_mem   [3][DEPTH];
    bit          ref_known [3][DEPTH];

    memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .MEM_INIT("")) u_l2 (
        .i_clk(clk), .i_arst(arst),
        .i_reqValid(req_vld[0]), .o_reqReady(req_rdy[0]), .i_reqAddress(req_adr[0]),
        .i_reqWriteEn(req_we[0]), .i_reqWriteData(req_wd[0]),
        .o_rspValid(rsp_vld[0]), .i_rspReady(rsp_rdy[0]),
        .o_rspReadData(rsp_dat[0]), .o_rspError(rsp_err[0])
    );

    memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .MEM_INIT("")) u_l0 (
        .i_clk(clk), .i_arst(arst),
        .i_reqValid(req_vld[1]), .o_reqReady(req_rdy[1]), .i_reqAddress(req_adr[1]),
        .i_reqWriteEn(req_we[1]), .i_reqWriteData(req_wd[1]),
        .o_rspValid(rsp_vld[1]), .i_rspReady(rsp_rdy[1]),
        .o_rspReadData(rsp_dat[1]), .o_rspError(rsp_err[1])
    );

    memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4), .MEM_INIT("")) u_l4 (
        .i_clk(clk), .i_arst(arst),
        .i_reqValid(req_vld[2]), .o_reqReady(req_rdy[2]), .i_reqAddress(req_adr[2]),
        .i_reqWriteEn(req_we[2]), .i_reqWriteData(req_wd[2]),
        .o_rspValid(rsp_vld[2]), .i_rspReady(rsp_rdy[2]),
        .o_rspReadData(rsp_dat[2]), .o_rspError(rsp_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 4);
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One complete request/response; stall > 0 holds i_rspReady low that many cycles
    // after valid while a competing request is presented.
    task automatic do_req(input int k, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdat, input int stall);
        int          waited;
        bit          err;
        bit          dat_known;
        int          idx;
        logic [31:0] exp_dat;
        err       = (addr % 4 != 0) || (addr / 4 >= DEPTH);
        idx       = int'((addr / 4) % DEPTH);
        dat_known = err || we || ref_known[k][idx];
        exp_dat   = (err || we) ? 32'd0 : ref_mem[k][idx];

        @(negedge clk);
        check32("req_ready_before", 32'(req_rdy[k]), 32'd1);
        req_vld[k] = 1'b1;
        req_adr[k] = addr;
        req_we[k]  = we;
        req_wd[k]  = wdat;
        rsp_rdy[k] = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        req_vld[k] = 1'b0;
        check32("req_ready_busy", 32'(req_rdy[k]), 32'd0);
        waited = 0;
        while (!rsp_vld[k] && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check32("rsp_latency", 32'(waited), 32'(lat_of(k) + 1));
        check32("rsp_error", 32'(rsp_err[k]), 32'(err));
        if (dat_known) check32("rsp_data", rsp_dat[k], exp_dat);
        if (we && !err) begin
            ref_mem[k][idx]   = wdat;
            ref_known[k][idx] = 1'b1;
        end

        for (int s = 0; s < stall; s++) begin
            req_vld[k] = 1'b1;
            req_adr[k] = 32'($urandom_range(0, 15)) * 4;
            req_we[k]  = 1'b1;
            req_wd[k]  = $urandom;
            @(negedge clk);
            check32("stall_valid", 32'(rsp_vld[k]), 32'd1);
            check32("stall_req_ready", 32'(req_rdy[k]), 32'd0);
            check32("stall_error", 32'(rsp_err[k]), 32'(err));
            if (dat_known) check32("stall_data", rsp_dat[k], exp_dat);
        end
        req_vld[k] = 1'b0;
        rsp_rdy[k] = 1'b1;

        @(negedge clk);
        check32("post_hs_valid", 32'(rsp_vld[k]), 32'd0);
        check32("post_hs_data", rsp_dat[k], 32'd0);
        check32("post_hs_error", 32'(rsp_err[k]), 32'd0);
        check32("post_hs_req_ready", 32'(req_rdy[k]), 32'd1);
    endtask

    initial begin
        int          k;
        int          r;
        logic [31:0] a;
        int          waited;

        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 3; i++) begin
            req_vld[i] = 1'b0;
            req_adr[i] = 32'd0;
            req_we[i]  = 1'b0;
            req_wd[i]  = 32'd0;
            rsp_rdy[i] = 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
                ref_mem[i][j]   = 32'd0;
                ref_known[i][j] = 1'b0;
            end
        end

        arst = 1'b1;
        #3;
        for (int i = 0; i < 3; i++) begin
            check32("reset_req_ready", 32'(req_rdy[i]), 32'd1);
            check32("reset_rsp_valid", 32'(rsp_vld[i]), 32'd0);
            check32("reset_rsp_data", rsp_dat[i], 32'd0);
            check32("reset_rsp_error", 32'(rsp_err[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        arst = 1'b0;

        // Write then read, LATENCY 2.
        do_req(0, 32'h10, 1'b1, 32'hDEADBEEF, 0);
        do_req(0, 32'h10, 1'b0, 32'h0, 0);
        check32("model_deadbeef", ref_mem[0][4], 32'hDEADBEEF);

        // Back-pressure for five cycles.
        do_req(0, 32'h10, 1'b0, 32'h0, 5);

        // Misaligned read and out-of-range write.
        do_req(0, 32'h12, 1'b0, 32'h0, 0);
        do_req(0, 32'h0, 1'b1, 32'hA5A50001, 0);
        do_req(0, 32'h100, 1'b1, 32'hBAD0BAD0, 0);
        do_req(0, 32'h0, 1'b0, 32'h0, 0);

        // LATENCY 0.
        do_req(1, 32'h4, 1'b1, 32'h00500093, 0);
        do_req(1, 32'h4, 1'b0, 32'h0, 0);

        // Reset mid-write on the LATENCY 4 instance: the pending write must be dropped.
        do_req(2, 32'h8, 1'b1, 32'h11111111, 0);
        @(negedge clk);
        req_vld[2] = 1'b1;
        req_adr[2] = 32'h8;
        req_we[2]  = 1'b1;
        req_wd[2]  = 32'h55;
        @(posedge clk);
        #1;
        req_vld[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b1;
        #1;
        check32("midwrite_req_ready", 32'(req_rdy[2]), 32'd1);
        check32("midwrite_rsp_valid", 32'(rsp_vld[2]), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        do_req(2, 32'h8, 1'b0, 32'h0, 0);

        // Asynchronous reset while a read response is being held.
        @(negedge clk);
        rsp_rdy[0] = 1'b0;
        req_vld[0] = 1'b1;
        req_adr[0] = 32'h10;
        req_we[0]  = 1'b0;
        @(negedge clk);
        req_vld[0] = 1'b0;
        waited = 0;
        while (!rsp_vld[0] && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check32("held_rsp_data", rsp_dat[0], 32'hDEADBEEF);
        #2;
        arst = 1'b1;
        #1;
        check32("async_req_ready", 32'(req_rdy[0]), 32'd1);
        check32("async_rsp_valid", 32'(rsp_vld[0]), 32'd0);
        check32("async_rsp_data", rsp_dat[0], 32'd0);
        @(negedge clk);
        arst       = 1'b0;
        rsp_rdy[0] = 1'b1;

        // Random traffic across all three instances.
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 15)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'($urandom_range(64, 4000)) * 4;
            else             a = 32'hFFFFFFFC;
            do_req(k, a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
